// File: rtl/lc3_int_pkg.sv
// Shared types and helpers for the LC-3 multi-channel interrupt controller.
package lc3_int_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } int_state_t;

    // Vector of a channel: base plus channel index, wrapping at 8 bits.
    function automatic logic [7:0] vec_of(input logic [7:0] base, input logic [7:0] ch);
        return base + ch;
    endfunction

endpackage

// File: rtl/lc3_int_arb.sv
// Combinational priority arbiter: highest priority wins, ties go to the lowest index,
// and the winner is only valid when it strictly exceeds the processor priority.
module lc3_int_arb #(
    parameter int NUM_CH = 8,
    parameter int PRIO_W = 3,
    parameter int CH_W   = 3
) (
    input  logic [NUM_CH-1:0]        cand,
    input  logic [NUM_CH*PRIO_W-1:0] ch_prio,
    input  logic [PRIO_W-1:0]        cpu_prio,
    output logic                     win_valid,
    output logic [CH_W-1:0]          win_ch,
    output logic [PRIO_W-1:0]        win_prio
);

    logic any_cand;

    // Ascending scan with a strict compare keeps the lowest index on ties.
    always_comb begin
        any_cand = 1'b0;
        win_ch   = '0;
        win_prio = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cand[c] && (!any_cand || (ch_prio[c*PRIO_W +: PRIO_W] > win_prio))) begin
                any_cand = 1'b1;
                win_ch   = CH_W'(c);
                win_prio = ch_prio[c*PRIO_W +: PRIO_W];
            end
        end
        win_valid = any_cand && (win_prio > cpu_prio);
    end

endmodule

// File: rtl/lc3_int_ctrl.sv
// LC-3 interrupt controller: per-channel edge/level pending, mask register,
// priority arbitration and a request/acknowledge handshake with held vector.
module lc3_int_ctrl
    import lc3_int_pkg::*;
#(
    parameter int                NUM_CH     = 8,
    parameter int                PRIO_W     = 3,
    parameter logic [7:0]        VEC_BASE   = 8'h80,
    parameter logic [NUM_CH-1:0] TRIG_LEVEL = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        irq_i,
    input  logic [NUM_CH*PRIO_W-1:0] ch_prio_i,
    input  logic [PRIO_W-1:0]        cpu_prio_i,
    input  logic                     mask_we_i,
    input  logic [NUM_CH-1:0]        mask_wdata_i,
    input  logic                     int_ack_i,
    output logic                     int_o,
    output logic [PRIO_W-1:0]        intp_o,
    output logic [7:0]               intv_o,
    output logic [NUM_CH-1:0]        pending_o,
    output logic [NUM_CH-1:0]        mask_o
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    int_state_t        state;
    logic [NUM_CH-1:0] irq_q;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] mask;
    logic [CH_W-1:0]   hold_ch;
    logic [PRIO_W-1:0] hold_prio;

    logic [NUM_CH-1:0] edge_set;
    logic [NUM_CH-1:0] ack_clr;
    logic [NUM_CH-1:0] pending_next;
    logic              ack_take;
    logic              withdraw;
    logic              win_valid;
    logic [CH_W-1:0]   win_ch;
    logic [PRIO_W-1:0] win_prio;

    assign pending_o = pending;
    assign mask_o    = mask;
    assign edge_set  = irq_i & ~irq_q;
    assign ack_take  = (state == REQ) && int_ack_i;
    assign withdraw  = mask[hold_ch] || !pending[hold_ch] || (cpu_prio_i >= hold_prio);

    // Set beats clear on edge channels; level channels simply follow the delayed line.
    always_comb begin
        ack_clr = '0;
        if (ack_take) begin
            ack_clr[hold_ch] = 1'b1;
        end
        pending_next = (TRIG_LEVEL & irq_q) | (~TRIG_LEVEL & ((pending & ~ack_clr) | edge_set));
    end

    lc3_int_arb #(
        .NUM_CH (NUM_CH),
        .PRIO_W (PRIO_W),
        .CH_W   (CH_W)
    ) u_arb (
        .cand      (pending & ~mask),
        .ch_prio   (ch_prio_i),
        .cpu_prio  (cpu_prio_i),
        .win_valid (win_valid),
        .win_ch    (win_ch),
        .win_prio  (win_prio)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q   <= '0;
            pending <= '0;
            mask    <= '1;
        end else begin
            irq_q   <= irq_i;
            pending <= pending_next;
            if (mask_we_i) begin
                mask <= mask_wdata_i;
            end
        end
    end

    // The vector and priority are captured once on entry to REQ and never re-arbitrated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            int_o     <= 1'b0;
            intp_o    <= '0;
            intv_o    <= '0;
            hold_ch   <= '0;
            hold_prio <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        state     <= REQ;
                        int_o     <= 1'b1;
                        hold_ch   <= win_ch;
                        hold_prio <= win_prio;
                        intp_o    <= win_prio;
                        intv_o    <= vec_of(VEC_BASE, 8'(win_ch));
                    end
                end
                REQ: begin
                    if (int_ack_i) begin
                        state <= WAIT;
                        int_o <= 1'b0;
                    end else if (withdraw) begin
                        state <= IDLE;
                        int_o <= 1'b0;
                    end
                end
                WAIT: begin
                    state <= IDLE;
                    int_o <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    int_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_int_ctrl.sv
// Directed table-driven bench for lc3_int_ctrl with hand sequences for level mode and reset.
module tb_lc3_int_ctrl;

    localparam int NUM_CH = 8;
    localparam int PRIO_W = 3;

    typedef struct {
        logic [7:0] irq;
        logic [2:0] cpu;
        logic       mwe;
        logic [7:0] mwd;
        logic       ack;
        logic       e_int;
        logic [2:0] e_intp;
        logic [7:0] e_intv;
        logic [7:0] e_pend;
        logic [7:0] e_mask;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  irq_i;
    logic [23:0] ch_prio_i;
    logic [2:0]  cpu_prio_i;
    logic        mask_we_i;
    logic [7:0]  mask_wdata_i;
    logic        int_ack_i;
    logic        int_o;
    logic [2:0]  intp_o;
    logic [7:0]  intv_o;
    logic [7:0]  pending_o;
    logic [7:0]  mask_o;

    int   tests = 0;
    int   fails = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    lc3_int_ctrl #(
        .NUM_CH     (NUM_CH),
        .PRIO_W     (PRIO_W),
        .VEC_BASE   (8'h80),
        .TRIG_LEVEL (8'h01)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_i        (irq_i),
        .ch_prio_i    (ch_prio_i),
        .cpu_prio_i   (cpu_prio_i),
        .mask_we_i    (mask_we_i),
        .mask_wdata_i (mask_wdata_i),
        .int_ack_i    (int_ack_i),
        .int_o        (int_o),
        .intp_o       (intp_o),
        .intv_o       (intv_o),
        .pending_o    (pending_o),
        .mask_o       (mask_o)
    );

    function automatic void addv(logic [7:0] irq, logic [2:0] cpu, logic mwe, logic [7:0] mwd,
                                 logic ack, logic e_int, logic [2:0] e_intp, logic [7:0] e_intv,
                                 logic [7:0] e_pend, logic [7:0] e_mask);
        vec_t v;
        v = '{irq, cpu, mwe, mwd, ack, e_int, e_intp, e_intv, e_pend, e_mask};
        vq.push_back(v);
    endfunction

    task automatic applyStimulus(input vec_t v);
        irq_i        = v.irq;
        cpu_prio_i   = v.cpu;
        mask_we_i    = v.mwe;
        mask_wdata_i = v.mwd;
        int_ack_i    = v.ack;
    endtask

    task automatic checkOutput(input string name, input int idx, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s (step %0d): got %0h, expected %0h", name, idx, actual, expected);
        end
    endtask

    initial begin
        // ch0=1 ch1=5 ch2=3 ch3=4 ch4=2 ch5=7 ch6=5 ch7=0
        ch_prio_i = {3'd0, 3'd5, 3'd7, 3'd2, 3'd4, 3'd3, 3'd5, 3'd1};

        //   irq   cpu mwe mwd   ack int intp intv   pend   mask
        addv(8'h00, 0, 1, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        addv(8'h08, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h08, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 0, 1, 4, 8'h83, 8'h08, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 1, 0, 4, 8'h83, 8'h00, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 0, 0, 4, 8'h83, 8'h00, 8'h00);
        addv(8'h42, 0, 0, 8'h00, 0, 0, 4, 8'h83, 8'h42, 8'h00);
        addv(8'h42, 0, 0, 8'h00, 0, 1, 5, 8'h81, 8'h42, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 1, 0, 5, 8'h81, 8'h40, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 0, 0, 5, 8'h81, 8'h40, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 0, 1, 5, 8'h86, 8'h40, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 1, 0, 5, 8'h86, 8'h00, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 0, 0, 5, 8'h86, 8'h00, 8'h00);
        addv(8'h04, 0, 0, 8'h00, 0, 0, 5, 8'h86, 8'h04, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 0, 1, 3, 8'h82, 8'h04, 8'h00);
        addv(8'h20, 0, 0, 8'h00, 0, 1, 3, 8'h82, 8'h24, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 0, 1, 3, 8'h82, 8'h24, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 1, 0, 3, 8'h82, 8'h20, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 0, 0, 3, 8'h82, 8'h20, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 0, 1, 7, 8'h85, 8'h20, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 1, 0, 7, 8'h85, 8'h00, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 0, 0, 7, 8'h85, 8'h00, 8'h00);
        addv(8'h10, 0, 0, 8'h00, 0, 0, 7, 8'h85, 8'h10, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 0, 1, 2, 8'h84, 8'h10, 8'h00);
        addv(8'h00, 2, 0, 8'h00, 0, 0, 2, 8'h84, 8'h10, 8'h00);
        addv(8'h00, 2, 0, 8'h00, 0, 0, 2, 8'h84, 8'h10, 8'h00);
        addv(8'h00, 1, 0, 8'h00, 0, 1, 2, 8'h84, 8'h10, 8'h00);
        addv(8'h00, 1, 0, 8'h00, 1, 0, 2, 8'h84, 8'h00, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 0, 0, 2, 8'h84, 8'h00, 8'h00);
        addv(8'h80, 0, 0, 8'h00, 0, 0, 2, 8'h84, 8'h80, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 0, 0, 2, 8'h84, 8'h80, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 0, 0, 2, 8'h84, 8'h80, 8'h00);
        addv(8'h08, 0, 0, 8'h00, 0, 0, 2, 8'h84, 8'h88, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 0, 1, 4, 8'h83, 8'h88, 8'h00);
        addv(8'h08, 0, 0, 8'h00, 1, 0, 4, 8'h83, 8'h88, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 0, 0, 4, 8'h83, 8'h88, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 0, 1, 4, 8'h83, 8'h88, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 1, 0, 4, 8'h83, 8'h80, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 0, 0, 4, 8'h83, 8'h80, 8'h00);
        addv(8'h08, 0, 0, 8'h00, 0, 0, 4, 8'h83, 8'h88, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 0, 1, 4, 8'h83, 8'h88, 8'h00);
        addv(8'h00, 0, 1, 8'h08, 0, 1, 4, 8'h83, 8'h88, 8'h08);
        addv(8'h00, 0, 0, 8'h00, 0, 0, 4, 8'h83, 8'h88, 8'h08);
        addv(8'h00, 0, 1, 8'h00, 0, 0, 4, 8'h83, 8'h88, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 0, 1, 4, 8'h83, 8'h88, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 1, 0, 4, 8'h83, 8'h80, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 1, 0, 4, 8'h83, 8'h80, 8'h00);
        addv(8'h08, 0, 0, 8'h00, 1, 0, 4, 8'h83, 8'h88, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 1, 1, 4, 8'h83, 8'h88, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 1, 0, 4, 8'h83, 8'h80, 8'h00);
        addv(8'h00, 0, 0, 8'h00, 0, 0, 4, 8'h83, 8'h80, 8'h00);

        rst_n = 1'b0;
        applyStimulus('{8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00});
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_int", 0, 32'(int_o), 32'd0);
        checkOutput("rst_intp", 0, 32'(intp_o), 32'd0);
        checkOutput("rst_intv", 0, 32'(intv_o), 32'd0);
        checkOutput("rst_pend", 0, 32'(pending_o), 32'd0);
        checkOutput("rst_mask", 0, 32'(mask_o), 32'hff);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            applyStimulus(vq[i]);
            @(posedge clk);
            #1;
            checkOutput("int", i, 32'(int_o), 32'(vq[i].e_int));
            checkOutput("intp", i, 32'(intp_o), 32'(vq[i].e_intp));
            checkOutput("intv", i, 32'(intv_o), 32'(vq[i].e_intv));
            checkOutput("pend", i, 32'(pending_o), 32'(vq[i].e_pend));
            checkOutput("mask", i, 32'(mask_o), 32'(vq[i].e_mask));
        end

        // Level channel 0 held high: ack leaves it pending and it re-requests after WAIT.
        @(negedge clk);
        irq_i = 8'h01;
        for (int n = 0; n < 6 && !int_o; n++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("lvl_req", 100, 32'(int_o), 32'd1);
        checkOutput("lvl_intv", 100, 32'(intv_o), 32'h80);
        checkOutput("lvl_intp", 100, 32'(intp_o), 32'd1);
        @(negedge clk);
        int_ack_i = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("lvl_ack_int", 101, 32'(int_o), 32'd0);
        checkOutput("lvl_ack_pend", 101, 32'(pending_o), 32'h81);
        @(negedge clk);
        int_ack_i = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("lvl_wait_int", 102, 32'(int_o), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("lvl_rereq", 103, 32'(int_o), 32'd1);
        @(negedge clk);
        irq_i = 8'h00;
        int_ack_i = 1'b1;
        @(negedge clk);
        int_ack_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("lvl_drop_int", 104, 32'(int_o), 32'd0);
        checkOutput("lvl_drop_pend", 104, 32'(pending_o), 32'h80);

        // Asynchronous reset in the middle of a request.
        @(negedge clk);
        irq_i = 8'h08;
        @(negedge clk);
        irq_i = 8'h00;
        @(posedge clk);
        #1;
        checkOutput("pre_rst_int", 110, 32'(int_o), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_int", 111, 32'(int_o), 32'd0);
        checkOutput("arst_intp", 111, 32'(intp_o), 32'd0);
        checkOutput("arst_intv", 111, 32'(intv_o), 32'd0);
        checkOutput("arst_pend", 111, 32'(pending_o), 32'd0);
        checkOutput("arst_mask", 111, 32'(mask_o), 32'hff);
        @(negedge clk);
        rst_n = 1'b1;
        irq_i = 8'h08;
        @(negedge clk);
        irq_i = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("masked_int", 112, 32'(int_o), 32'd0);
        checkOutput("masked_pend", 112, 32'(pending_o), 32'h08);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lc3_int_ctrl.md
# lc3_int_ctrl

Parametrised multi-channel interrupt controller for the LC-3 core. It replaces the single IRQ/INTP/INTV latch with per-channel pending and mask registers, a configurable per-channel trigger mode, priority arbitration, and a request/acknowledge handshake toward the control FSM. It sits between the peripherals and the datapath/control:
- it compares the winning priority against PSR[10:8];
- it holds a stable vector and priority from request until acknowledge.

## Interface
- NUM_CH, 8, number of interrupt channels (2..16)
- PRIO_W, 3, priority width (matches PSR[10:8])
- VEC_BASE, 8'h80, vector of channel 0; channel c uses VEC_BASE + c (8-bit wrap)
- TRIG_LEVEL, '0, NUM_CH-bit mask; bit c=1 makes channel c level-triggered, 0 makes it rising-edge-triggered

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- irq_i  in  NUM_CH  interrupt request lines, synchronous to clk
- ch_prio_i  in  NUM_CH*PRIO_W  static priority per channel; channel c uses bits [c*PRIO_W +: PRIO_W]
- cpu_prio_i  in  PRIO_W  current processor priority (PSR[10:8])
- mask_we_i  in  1  write strobe for the mask register
- mask_wdata_i  in  NUM_CH  new mask; a 1 bit disables the channel
- int_ack_i  in  1  one-cycle acknowledge from control
- int_o  out  1  interrupt request to control
- intp_o  out  PRIO_W  priority of the held request
- intv_o  out  8  vector of the held request
- pending_o  out  NUM_CH  pending register
- mask_o  out  NUM_CH  mask register

## Operation
- Edge channel: pending[c] sets on irq_i[c] & ~irq_q[c], where irq_q is the registered copy of irq_i. It clears on an acknowledge that grants c. If a set and a clear hit the same channel in the same cycle, set wins.
- Level channel: pending[c] = irq_q[c] registered. Acknowledge does not clear it; the device must drop the line.
- Candidate = pending & ~mask. The arbiter picks the highest ch_prio among candidates; ties go to the lowest index. The candidate is valid only if its priority > cpu_prio_i (strict). Priority 0 therefore never interrupts.
- FSM states: IDLE, REQ, WAIT.
  - IDLE → REQ when a valid candidate exists. On that edge, hold_ch and hold_prio latch the winner.
  - REQ: int_o = 1. intp_o and intv_o come from the hold registers and do not re-arbitrate, even if a higher-priority channel arrives.
  - REQ → WAIT on int_ack_i. On that edge the pending bit of hold_ch clears (edge mode only).
  - REQ → IDLE (withdraw) when, with no ack, hold_ch becomes masked, is no longer pending, or cpu_prio_i ≥ hold_prio. Ack in the same cycle as a withdraw condition: ack wins.
  - WAIT → IDLE unconditionally. This gives control one cycle to update the PSR priority.
- int_ack_i is ignored outside REQ.
- Mask write: mask_o updates on the edge after mask_we_i. The new value affects the withdraw check one cycle later.
- Reset (asynchronous, any state): state = IDLE, int_o = 0, intp_o = 0, intv_o = 0, pending_o = 0, irq_q = 0, mask_o = all ones (every channel masked).

## Timing
- irq_i[c] is sampled high at edge k: pending[c] = 1 after edge k.
- If the candidate is valid, int_o = 1 after edge k+1 (2-cycle latency).
- int_ack_i is sampled at edge a: int_o = 0 after edge a, and the state is WAIT. After a+1 the state is IDLE. The earliest next int_o is after edge a+2.
- intp_o and intv_o are registered. They change only on IDLE→REQ and hold their value through WAIT and IDLE until the next REQ.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package lc3_int_pkg:
  - typedef int_state_t {IDLE, REQ, WAIT};
  - function vec_of(ch).
- Sub-module lc3_int_arb: combinational priority arbiter, parametrised on NUM_CH and PRIO_W. Outputs: win_valid, win_ch, win_prio.
- Top level holds the edge-detect, pending, mask and hold registers and the FSM.

## Test plan
- Reset with mask 0 written, cpu_prio 0, ch3 prio 4. Pulse irq_i[3] for 1 cycle → int_o high 2 cycles later, intp_o = 4, intv_o = 8'h83. Ack → pending[3] = 0, int_o low next cycle.
- ch1 prio 5 and ch6 prio 5 rise together → ch1 wins (intv_o = 8'h81). After ack plus WAIT, ch6 is requested (8'h86).
- While in REQ on ch2 (prio 3), ch5 (prio 7) rises → intv_o stays 8'h82 until ack; then the ch5 request follows.
- In REQ on ch4 (prio 2), drive cpu_prio_i = 2 → int_o drops next cycle with no ack, and pending[4] stays 1. Lower cpu_prio_i to 1 → int_o re-asserts.
- Level channel 0 (TRIG_LEVEL = 1) held high: ack → pending[0] stays 1, and int_o re-asserts after WAIT (cpu_prio unchanged).
- Assert rst_n low mid-REQ → int_o, pending_o, intv_o go to 0 immediately, and mask_o goes to all ones. The same-cycle edge-set/ack-clear case on a single channel leaves pending = 1.
